// File: rtl/alarm_sequencer_if.sv
// Signal bundle between the alarm sequencer and its surroundings: time/alarm
// values and button pulses in, status indicators and buzzer enable out.
interface alarm_sequencer_if;
  logic       sec_tick;
  logic [4:0] cur_hh;
  logic [5:0] cur_mm;
  logic [4:0] alm_hh;
  logic [5:0] alm_mm;
  logic       arm_toggle;
  logic       snooze;
  logic       stop;
  logic       armed;
  logic       ringing;
  logic       snoozing;
  logic       buzz;
  logic [2:0] snooze_cnt;

  // Driver side: timekeeping, button logic and the bench.
  modport master (
    output sec_tick, cur_hh, cur_mm, alm_hh, alm_mm, arm_toggle, snooze, stop,
    input  armed, ringing, snoozing, buzz, snooze_cnt
  );

  // Sequencer side.
  modport slave (
    input  sec_tick, cur_hh, cur_mm, alm_hh, alm_mm, arm_toggle, snooze, stop,
    output armed, ringing, snoozing, buzz, snooze_cnt
  );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm state controller: disarmed / armed / ringing / snooze sequencing.
// Define ALARM_BEEP_PATTERN_EN for a 1 s on / 1 s off buzzer instead of a continuous tone.
module alarm_sequencer #(
  parameter int SNOOZE_MIN     = 9,
  parameter int MAX_SNOOZE     = 3,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic              clk,
  input  logic              rst,
  alarm_sequencer_if.slave  bus
);

  localparam int                SNZ_LOAD  = SNOOZE_MIN * 60;
  localparam int                SNZ_W     = $clog2(SNZ_LOAD + 1);
  localparam logic [SNZ_W-1:0]  SNZ_INIT  = SNZ_W'(SNZ_LOAD);
  localparam logic [SNZ_W-1:0]  SNZ_ONE   = SNZ_W'(1);
  localparam logic [9:0]        RING_LAST = 10'(RING_TIMEOUT_S - 1);
  localparam logic [2:0]        SNZ_LIMIT = 3'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_RINGING  = 2'd2,
    S_SNOOZE   = 2'd3
  } state_e;

  state_e            state_q,    state_d;
  logic              match_q;
  logic [2:0]        snz_cnt_q,  snz_cnt_d;
  logic [9:0]        ring_sec_q, ring_sec_d;
  logic [SNZ_W-1:0]  snz_sec_q,  snz_sec_d;
  logic              match;
  logic              trigger;

  // Only a rising edge of the time match fires, so arming during a match stays quiet.
  assign match   = (bus.cur_hh == bus.alm_hh) && (bus.cur_mm == bus.alm_mm);
  assign trigger = match && !match_q;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    snz_cnt_d  = snz_cnt_q;
    ring_sec_d = ring_sec_q;
    snz_sec_d  = snz_sec_q;

    unique case (state_q)
      S_DISARMED: begin
        if (bus.arm_toggle) state_d = S_ARMED;
      end

      S_ARMED: begin
        if (bus.arm_toggle) begin
          state_d = S_DISARMED;
        end else if (trigger) begin
          state_d    = S_RINGING;
          snz_cnt_d  = 3'd0;
          ring_sec_d = 10'd0;
        end
      end

      S_RINGING: begin
        if (bus.arm_toggle) begin
          state_d = S_DISARMED;
        end else if (bus.stop) begin
          state_d = S_ARMED;
        end else if (bus.snooze && (snz_cnt_q < SNZ_LIMIT)) begin
          state_d   = S_SNOOZE;
          snz_cnt_d = snz_cnt_q + 3'd1;
          snz_sec_d = SNZ_INIT;
        end else if (bus.sec_tick) begin
          ring_sec_d = ring_sec_q + 10'd1;
          if (ring_sec_q == RING_LAST) state_d = S_ARMED;
        end
      end

      S_SNOOZE: begin
        if (bus.arm_toggle) begin
          state_d = S_DISARMED;
        end else if (bus.stop) begin
          state_d = S_ARMED;
        end else if (bus.sec_tick) begin
          if (snz_sec_q <= SNZ_ONE) begin
            state_d    = S_RINGING;
            snz_sec_d  = '0;
            ring_sec_d = 10'd0;
          end else begin
            snz_sec_d = snz_sec_q - SNZ_ONE;
          end
        end
      end

      default: state_d = S_DISARMED;
    endcase

    // Leaving the alarm event by any route starts the next event with a fresh snooze budget.
    if (state_d == S_DISARMED || state_d == S_ARMED) snz_cnt_d = 3'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_DISARMED;
      match_q    <= 1'b1;
      snz_cnt_q  <= 3'd0;
      ring_sec_q <= 10'd0;
      snz_sec_q  <= '0;
    end else begin
      state_q    <= state_d;
      match_q    <= match;
      snz_cnt_q  <= snz_cnt_d;
      ring_sec_q <= ring_sec_d;
      snz_sec_q  <= snz_sec_d;
    end
  end

  assign bus.armed      = (state_q != S_DISARMED);
  assign bus.ringing    = (state_q == S_RINGING);
  assign bus.snoozing   = (state_q == S_SNOOZE);
  assign bus.snooze_cnt = snz_cnt_q;

`ifdef ALARM_BEEP_PATTERN_EN
  logic beep_phase_q, beep_phase_d;

  // Starts "on" at ring entry and flips each second while ringing.
  always_comb begin
    beep_phase_d = 1'b0;
    if (state_d == S_RINGING) begin
      if (state_q != S_RINGING) beep_phase_d = 1'b1;
      else if (bus.sec_tick)    beep_phase_d = ~beep_phase_q;
      else                      beep_phase_d = beep_phase_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) beep_phase_q <= 1'b0;
    else     beep_phase_q <= beep_phase_d;
  end

  assign bus.buzz = bus.ringing && beep_phase_q;
`else
  assign bus.buzz = bus.ringing;
`endif

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: directed scenarios plus randomized
// traffic, all compared against an event-level reference model.
module tb_alarm_sequencer;
  localparam int SNOOZE_MIN     = 9;
  localparam int MAX_SNOOZE     = 3;
  localparam int RING_TIMEOUT_S = 60;
  localparam int SNZ_TICKS      = SNOOZE_MIN * 60;

  // Model modes
  localparam int M_OFF   = 0;
  localparam int M_ARMED = 1;
  localparam int M_RING  = 2;
  localparam int M_SNZ   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alarm_sequencer_if sif ();

  alarm_sequencer #(
    .SNOOZE_MIN    (SNOOZE_MIN),
    .MAX_SNOOZE    (MAX_SNOOZE),
    .RING_TIMEOUT_S(RING_TIMEOUT_S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the alarm event in terms of mode, snoozes used and seconds.
  int mode;
  int used;
  int ring_elapsed;
  int snooze_left;
  bit prev_match;
  bit beep_on;

  task automatic model_reset();
    mode         = M_OFF;
    used         = 0;
    ring_elapsed = 0;
    snooze_left  = 0;
    prev_match   = 1'b1;
    beep_on      = 1'b0;
  endtask

  task automatic start_ring();
    mode         = M_RING;
    ring_elapsed = 0;
    beep_on      = 1'b1;
  endtask

  task automatic model_step(input bit tick, input bit arm, input bit snz, input bit stp);
    bit now_match, rise;
    now_match  = (sif.cur_hh == sif.alm_hh) && (sif.cur_mm == sif.alm_mm);
    rise       = now_match && !prev_match;
    prev_match = now_match;
    case (mode)
      M_OFF:   if (arm) mode = M_ARMED;
      M_ARMED: begin
        if (arm) mode = M_OFF;
        else if (rise) begin used = 0; start_ring(); end
      end
      M_RING: begin
        if (arm) mode = M_OFF;
        else if (stp) mode = M_ARMED;
        else if (snz && used < MAX_SNOOZE) begin
          mode = M_SNZ; used++; snooze_left = SNZ_TICKS;
        end else if (tick) begin
          ring_elapsed++;
          beep_on = !beep_on;
          if (ring_elapsed == RING_TIMEOUT_S) mode = M_ARMED;
        end
      end
      default: begin
        if (arm) mode = M_OFF;
        else if (stp) mode = M_ARMED;
        else if (tick) begin
          snooze_left--;
          if (snooze_left == 0) start_ring();
        end
      end
    endcase
    if (mode != M_RING) beep_on = 1'b0;
    if (mode == M_OFF || mode == M_ARMED) used = 0;
  endtask

  function automatic logic [6:0] expected();
    logic bz;
`ifdef ALARM_BEEP_PATTERN_EN
    bz = (mode == M_RING) && beep_on;
`else
    bz = (mode == M_RING);
`endif
    return {mode != M_OFF, mode == M_RING, mode == M_SNZ, bz, 3'(used)};
  endfunction

  function automatic logic [6:0] observed();
    return {sif.armed, sif.ringing, sif.snoozing, sif.buzz, sif.snooze_cnt};
  endfunction

  // Status without buzz, for directed checks that hold in either buzzer mode.
  function automatic logic [5:0] status();
    return {sif.armed, sif.ringing, sif.snoozing, sif.snooze_cnt};
  endfunction

  task automatic set_time(input int ch, input int cm, input int ah, input int am);
    sif.cur_hh = 5'(ch);
    sif.cur_mm = 6'(cm);
    sif.alm_hh = 5'(ah);
    sif.alm_mm = 6'(am);
  endtask

  // Called at a negedge: present pulses for one clock, advance the model, return at next negedge.
  task automatic drive(input bit tick, input bit arm, input bit snz, input bit stp);
    sif.sec_tick   = tick;
    sif.arm_toggle = arm;
    sif.snooze     = snz;
    sif.stop       = stp;
    @(posedge clk);
    model_step(tick, arm, snz, stp);
    @(negedge clk);
    sif.sec_tick   = 1'b0;
    sif.arm_toggle = 1'b0;
    sif.snooze     = 1'b0;
    sif.stop       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_time(0, 0, 0, 0);
    sif.sec_tick = 1'b0; sif.arm_toggle = 1'b0; sif.snooze = 1'b0; sif.stop = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if (observed() !== 7'b0) begin
      bad++; $display("FAIL reset_outputs: got %b want %b", observed(), 7'b0);
    end
    rst = 1'b0;
    drive(0, 0, 0, 0);
    total++;
    if (observed() !== expected()) begin
      bad++; $display("FAIL reset_idle: got %b want %b", observed(), expected());
    end
  endtask

  task automatic test_ring_on_match();
    drive(0, 1, 0, 0);
    total++;
    if (status() !== 6'b100_000) begin
      bad++; $display("FAIL arm: got %b want %b", status(), 6'b100_000);
    end
    set_time(7, 29, 7, 30);
    drive(0, 0, 0, 0);
    set_time(7, 30, 7, 30);
    drive(0, 0, 0, 0);
    total++;
    if (observed() !== 7'b1101_000) begin
      bad++; $display("FAIL ring_start: got %b want %b", observed(), 7'b1101_000);
    end
    total++;
    if (observed() !== expected()) begin
      bad++; $display("FAIL ring_start_model: got %b want %b", observed(), expected());
    end
  endtask

  task automatic test_snooze();
    drive(0, 0, 1, 0);
    total++;
    if (observed() !== 7'b1010_001) begin
      bad++; $display("FAIL snooze_enter: got %b want %b", observed(), 7'b1010_001);
    end
    for (int k = 1; k <= SNZ_TICKS; k++) begin
      drive(1, 0, 0, 0);
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL snooze_tick%0d: got %b want %b", k, observed(), expected());
      end
      if (k == SNZ_TICKS - 1) begin
        total++;
        if (status() !== 6'b101_001) begin
          bad++; $display("FAIL snooze_539: got %b want %b", status(), 6'b101_001);
        end
      end
    end
    total++;
    if (status() !== 6'b110_001) begin
      bad++; $display("FAIL snooze_expire: got %b want %b", status(), 6'b110_001);
    end
  endtask

  task automatic test_max_snooze();
    for (int n = 2; n <= MAX_SNOOZE; n++) begin
      drive(0, 0, 1, 0);
      total++;
      if (status() !== {3'b101, 3'(n)}) begin
        bad++; $display("FAIL snooze_n%0d: got %b want %b", n, status(), {3'b101, 3'(n)});
      end
      for (int k = 0; k < SNZ_TICKS; k++) begin
        drive(1, 0, 0, 0);
        total++;
        if (observed() !== expected()) begin
          bad++; $display("FAIL snooze_n%0d_tick: got %b want %b", n, observed(), expected());
        end
      end
    end
    drive(0, 0, 1, 0);
    total++;
    if (status() !== 6'b110_011) begin
      bad++; $display("FAIL snooze_ignored: got %b want %b", status(), 6'b110_011);
    end
    drive(0, 0, 0, 1);
    total++;
    if (status() !== 6'b100_000) begin
      bad++; $display("FAIL stop: got %b want %b", status(), 6'b100_000);
    end
  endtask

  task automatic test_timeout();
    set_time(7, 29, 7, 30);
    drive(0, 0, 0, 0);
    set_time(7, 30, 7, 30);
    drive(0, 0, 0, 0);
    for (int k = 1; k <= RING_TIMEOUT_S; k++) begin
      drive(1, 0, 0, 0);
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL timeout_tick%0d: got %b want %b", k, observed(), expected());
      end
`ifdef ALARM_BEEP_PATTERN_EN
      if (k < RING_TIMEOUT_S) begin
        total++;
        if (sif.buzz !== logic'(k % 2 == 0)) begin
          bad++; $display("FAIL beep_tick%0d: got %b want %b", k, sif.buzz, k % 2 == 0);
        end
      end
`endif
    end
    total++;
    if (status() !== 6'b100_000) begin
      bad++; $display("FAIL timeout_end: got %b want %b", status(), 6'b100_000);
    end
    set_time(7, 29, 7, 30);
    drive(0, 0, 0, 0);
    set_time(7, 30, 7, 30);
    drive(0, 0, 0, 0);
    total++;
    if (status() !== 6'b110_000) begin
      bad++; $display("FAIL ring_again: got %b want %b", status(), 6'b110_000);
    end
  endtask

  task automatic test_arm_while_match();
    drive(0, 1, 0, 1);
    total++;
    if (observed() !== 7'b0) begin
      bad++; $display("FAIL arm_stop_same_cycle: got %b want %b", observed(), 7'b0);
    end
    drive(0, 1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      drive(k[0], 0, 0, 0);
      total++;
      if (status() !== 6'b100_000) begin
        bad++; $display("FAIL armed_on_match: got %b want %b", status(), 6'b100_000);
      end
    end
    set_time(7, 29, 7, 30);
    drive(0, 0, 0, 0);
    set_time(7, 30, 7, 30);
    drive(0, 0, 0, 0);
    set_time(7, 30, 8, 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 0);
      total++;
      if (status() !== 6'b110_000 || observed() !== expected()) begin
        bad++; $display("FAIL alm_change_mid_ring: got %b want %b", observed(), expected());
      end
    end
  endtask

  task automatic test_reset_mid_snooze();
    drive(0, 0, 1, 0);
    repeat (3) drive(1, 0, 0, 0);
    total++;
    if (status() !== 6'b101_001) begin
      bad++; $display("FAIL pre_reset_snooze: got %b want %b", status(), 6'b101_001);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (observed() !== 7'b0) begin
      bad++; $display("FAIL async_reset: got %b want %b", observed(), 7'b0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0);
    total++;
    if (observed() !== expected()) begin
      bad++; $display("FAIL post_reset: got %b want %b", observed(), expected());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0)
        set_time(7, int'($urandom_range(29, 30)), 7,
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(29, 31)) : 30);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 59) == 0,
            $urandom_range(0, 7) == 0,  $urandom_range(0, 39) == 0);
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL random_c%0d: got %b want %b", c, observed(), expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_ring_on_match();
    test_snooze();
    test_max_snooze();
    test_timeout();
    test_arm_while_match();
    test_reset_mid_snooze();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

endmodule
